// File: rtl/color_sequencer_if.sv
// Control and colour-word bundle between the colour sequencer and its driver side.
interface color_sequencer_if;
    logic        enable;
    logic        mode;
    logic        step_up;
    logic        step_dn;
    logic [23:0] color;
    logic [2:0]  index;
    logic        fading;
    logic        wrap;

    modport master (
        output enable, mode, step_up, step_dn,
        input  color, index, fading, wrap
    );

    modport slave (
        input  enable, mode, step_up, step_dn,
        output color, index, fading, wrap
    );
endinterface

// File: rtl/color_sequencer.sv
// Rainbow palette sequencer: timed auto-advance, manual stepping, hard cut or
// linear cross-fade between entries, feeding the RGB PWM driver.
module color_fade_lane (
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [8:0] kp1,
    output logic [7:0] nxt
);
    logic signed [17:0] diff;
    logic signed [17:0] mul;
    logic signed [17:0] prod;

    // |diff * kp1| <= 255*256, so 18 signed bits hold it; >>> floors toward -inf
    assign diff = 18'($signed({1'b0, dst}) - $signed({1'b0, src}));
    assign mul  = $signed({9'b0, kp1});
    assign prod = diff * mul;
    assign nxt  = 8'($signed({10'b0, src}) + (prod >>> 8));
endmodule

module color_sequencer #(
    parameter int HOLD_CYCLES      = 25000000,
    parameter int FADE_STEP_CYCLES = 48828
) (
    input  logic              CLK,
    input  logic              RST_N,
    color_sequencer_if.slave  bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
    localparam int NUM_CH = 3;

    typedef enum logic {HOLD, FADE} state_t;

    state_t                     state_q, state_n;
    logic [2:0]                 index_q, index_n;
    logic [NUM_CH-1:0][7:0]     color_q, color_n;
    logic [NUM_CH-1:0][7:0]     src_q, src_n;
    logic [NUM_CH-1:0][7:0]     dst_col, fade_col;
    logic [8:0]                 k_q, k_n, kp1;
    logic [SW-1:0]              sc_q, sc_n;
    logic [HW-1:0]              hc_q, hc_n;
    logic                       wrap_q, wrap_n;

    logic       manual, start;
    logic [2:0] up_dst, dn_dst, dst;

    function automatic logic [23:0] pal(input logic [2:0] i);
        case (i)
            3'd0:    pal = 24'h9400D3;
            3'd1:    pal = 24'h4B0082;
            3'd2:    pal = 24'h0000FF;
            3'd3:    pal = 24'h00FF00;
            3'd4:    pal = 24'hFFFF00;
            3'd5:    pal = 24'hFF7F00;
            3'd6:    pal = 24'hFA1010;
            default: pal = 24'h9400D3;
        endcase
    endfunction

    assign dst_col = pal(index_q);
    assign kp1     = k_q + 9'd1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        color_fade_lane u_lane (
            .src (src_q[g]),
            .dst (dst_col[g]),
            .kp1 (kp1),
            .nxt (fade_col[g])
        );
    end

    assign manual = bus.step_up ^ bus.step_dn;
    assign up_dst = (index_q == 3'd6) ? 3'd0 : index_q + 3'd1;
    assign dn_dst = (index_q == 3'd0) ? 3'd6 : index_q - 3'd1;

    always_comb begin
        state_n = state_q;
        index_n = index_q;
        color_n = color_q;
        src_n   = src_q;
        k_n     = k_q;
        sc_n    = sc_q;
        hc_n    = hc_q;
        wrap_n  = 1'b0;
        start   = 1'b0;
        dst     = up_dst;

        // Manual steps win over both hold expiry and an in-progress fade step
        if (manual) begin
            start = 1'b1;
            dst   = bus.step_up ? up_dst : dn_dst;
        end else begin
            case (state_q)
                HOLD: begin
                    hc_n = hc_q + HW'(1);
                    if (hc_q == HW'(HOLD_CYCLES - 1))
                        start = 1'b1;
                end
                FADE: begin
                    sc_n = sc_q + SW'(1);
                    if (sc_q == SW'(FADE_STEP_CYCLES - 1)) begin
                        sc_n    = '0;
                        k_n     = kp1;
                        color_n = fade_col;
                        if (kp1 == 9'd256) begin
                            state_n = HOLD;
                            hc_n    = '0;
                        end
                    end
                end
                default: state_n = HOLD;
            endcase
        end

        if (start) begin
            index_n = dst;
            hc_n    = '0;
            wrap_n  = (index_q == 3'd6) && (dst == 3'd0);
            if (!bus.mode) begin
                color_n = pal(dst);
                state_n = HOLD;
            end else begin
                // Fade restarts from whatever is on the wire, not the old target
                src_n   = color_q;
                k_n     = '0;
                sc_n    = '0;
                state_n = FADE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= HOLD;
            index_q <= 3'd0;
            color_q <= 24'h9400D3;
            src_q   <= 24'h9400D3;
            k_q     <= '0;
            sc_q    <= '0;
            hc_q    <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.enable) begin
            state_q <= state_n;
            index_q <= index_n;
            color_q <= color_n;
            src_q   <= src_n;
            k_q     <= k_n;
            sc_q    <= sc_n;
            hc_q    <= hc_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.color  = color_q;
    assign bus.index  = index_q;
    assign bus.fading = (state_q == FADE);
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: table of hold/step/freeze vectors plus
// hand-written fade, abort, freeze-mid-fade and async reset sequences.
module tb_color_sequencer;
    logic CLK;
    logic RST_N;
    int   total;
    int   passed;

    color_sequencer_if bus();

    color_sequencer #(.HOLD_CYCLES(10), .FADE_STEP_CYCLES(1)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en, md, up, dn;
        int          n;
        logic [23:0] col;
        logic [2:0]  idx;
        logic        fad, wr;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic md, input logic up, input logic dn);
        bus.enable  = en;
        bus.mode    = md;
        bus.step_up = up;
        bus.step_dn = dn;
    endtask

    task automatic chk_all(input string nm, input logic [23:0] col, input logic [2:0] idx,
                           input logic fad, input logic wr);
        chk({nm, " color"},  bus.color, col);
        chk({nm, " index"},  {21'b0, bus.index}, {21'b0, idx});
        chk({nm, " fading"}, {23'b0, bus.fading}, {23'b0, fad});
        chk({nm, " wrap"},   {23'b0, bus.wrap}, {23'b0, wr});
    endtask

    // Asserted a couple of ns after an edge, checked before the next one
    task automatic pulse_reset(input string nm);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all(nm, 24'h9400D3, 3'd0, 1'b0, 1'b0);
        #3;
        RST_N = 1'b1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        RST_N  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //              en    md    up    dn    n   color        idx   fad   wr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h4B0082, 3'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'h4B0082, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h0000FF, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'h0000FF, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h00FF00, 3'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'h00FF00, 3'd3, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'hFFFF00, 3'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'hFFFF00, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'hFF7F00, 3'd5, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'hFF7F00, 3'd5, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'hFA1010, 3'd6, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  9, 24'hFA1010, 3'd6, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h9400D3, 3'd0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, 24'hFA1010, 3'd6, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1,  1, 24'hFA1010, 3'd6, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0,  1, 24'h9400D3, 3'd0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 50, 24'h9400D3, 3'd0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 50, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0,  5, 24'h9400D3, 3'd0, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h4B0082, 3'd1, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, 24'h9400D3, 3'd0, 1'b0, 1'b0};

        #12;
        chk_all("reset", 24'h9400D3, 3'd0, 1'b0, 1'b0);
        RST_N = 1'b1;

        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].en, tbl[r].md, tbl[r].up, tbl[r].dn);
            for (int c = 0; c < tbl[r].n; c++) begin
                cyc();
                chk_all($sformatf("row%0d", r), tbl[r].col, tbl[r].idx, tbl[r].fad, tbl[r].wr);
            end
        end

        // Full cross-fade 9400D3 -> 4B0082, then a fresh 10-cycle hold
        pulse_reset("rst f1");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc();
        chk_all("f1 start", 24'h9400D3, 3'd1, 1'b1, 1'b0);
        cyc();
        chk("f1 step1", bus.color, 24'h9300D2);
        repeat (127) cyc();
        chk("f1 step128", bus.color, 24'h6F00AA);
        repeat (127) cyc();
        chk("f1 step255 fading", {23'b0, bus.fading}, 24'd1);
        cyc();
        chk_all("f1 done", 24'h4B0082, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) cyc();
        chk_all("f1 hold9", 24'h4B0082, 3'd1, 1'b0, 1'b0);
        cyc();
        chk_all("f1 hold10", 24'h0000FF, 3'd2, 1'b0, 1'b0);

        // Fade aborted by step_up at step 100, then frozen mid-fade
        pulse_reset("rst f2");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc();
        repeat (100) cyc();
        chk_all("f2 step100", 24'h7700B3, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        chk_all("f2 abort", 24'h7700B3, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("f2 new step1", bus.color, 24'h7600B3);
        repeat (127) cyc();
        chk("f2 new step128", bus.color, 24'h3B00D9);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (50) cyc();
        chk_all("f2 frozen", 24'h3B00D9, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        chk_all("f2 resume", 24'h3A00D9, 3'd2, 1'b1, 1'b0);
        repeat (126) cyc();
        chk_all("f2 done", 24'h0000FF, 3'd2, 1'b0, 1'b0);

        // Hard-cut step during a fade, then async reset mid-fade
        repeat (10) cyc();
        chk_all("f3 start", 24'h0000FF, 3'd3, 1'b1, 1'b0);
        repeat (5) cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        chk_all("f3 cut", 24'h0000FF, 3'd2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc();
        repeat (3) cyc();
        chk_all("f3 step3", 24'h0002FC, 3'd3, 1'b1, 1'b0);
        pulse_reset("rst midfade");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Upstream colour source for the RGB PWM driver: produces the 24-bit RGB colour word the driver consumes.
- Steps through a fixed 7-entry rainbow palette, auto-advancing on a hold timer. Transitions are either a hard cut or a linear cross-fade.
- Debounced up/down button pulses step the palette manually.
- Replaces the free-running colour counter in the LED top level.

Parameters:
- HOLD_CYCLES, 25000000, enabled CLK cycles a colour is held before auto-advance (>=1).
- FADE_STEP_CYCLES, 48828, enabled CLK cycles per fade step; a full fade is 256 steps (>=1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- enable  in  1  high = run; low = freeze all state and outputs.
- mode  in  1  0 = hard cut, 1 = cross-fade; sampled at the start of each transition.
- step_up  in  1  single-cycle debounced pulse: advance to the next palette entry.
- step_dn  in  1  single-cycle debounced pulse: go back to the previous palette entry.
- color  out  24  {R[23:16],G[15:8],B[7:0]} to the PWM driver.
- index  out  3  current target palette index, 0..6.
- fading  out  1  high while in FADE.
- wrap  out  1  one-cycle pulse when index moves 6->0.

Behaviour:
- Palette, index 0..6: 9400D3, 4B0082, 0000FF, 00FF00, FFFF00, FF7F00, FA1010. Fixed constants.
- Reset (RST_N low, asynchronous):
  - state=HOLD, index=0, color=9400D3.
  - hold_cnt=0, k=0, fading=0, wrap=0.
- States: HOLD, FADE.
- enable=0:
  - No counter, state or output changes.
  - step_up/step_dn are ignored, not queued.
- HOLD:
  - hold_cnt increments each enabled cycle.
  - When hold_cnt reaches HOLD_CYCLES-1: start a transition with dst=index+1 (6 wraps to 0).
- Manual step, in HOLD or FADE:
  - step_up alone starts a transition to index+1.
  - step_dn alone starts a transition to index-1 (0 wraps to 6).
  - step_up and step_dn in the same cycle: both ignored.
  - A manual step in the same cycle as hold expiry takes priority over the auto-advance.
- Starting a transition (registered, visible next cycle):
  - index<=dst; hold_cnt<=0; wrap<=1 iff the old index was 6 and the new index is 0.
  - mode=0: color<=palette[dst]; stay in HOLD.
  - mode=1: src<=current color; k<=0; step_cnt<=0; go to FADE; color unchanged on that cycle.
- FADE:
  - step_cnt counts enabled cycles. At FADE_STEP_CYCLES-1: step_cnt<=0 and k<=k+1.
  - Each channel: color_ch<=src_ch+((dst_ch-src_ch)*(k+1))>>>8.
  - The difference is signed 9-bit, the product signed 18-bit, and the shift arithmetic (floor).
  - k is 9-bit, 0..256.
  - At k+1=256 the formula yields dst exactly: go to HOLD, hold_cnt<=0, fading<=0.
- Manual step during FADE:
  - Abort the fade: src<=current color (not the old dst); k<=0.
  - New dst from the current index ±1; stay in FADE.
  - With mode=0, cut directly to the new dst and go to HOLD.
- Outputs:
  - fading is high in every cycle the state is FADE.
  - color changes only on registered edges; no combinational path from inputs to outputs.
- Reset asserted mid-fade: immediate return to reset values; no partial colour is retained.

Test Plan (HOLD_CYCLES=10, FADE_STEP_CYCLES=1 unless noted):
- Reset then enable=1, mode=0, no buttons -> color=9400D3 for 10 cycles, then 4B0082 and index=1. After 7 holds: index 6->0, wrap pulses exactly 1 cycle, color=9400D3.
- mode=1 from index 0 -> fading rises and color moves from 9400D3 toward 4B0082. After 128 steps, R=0x6F (0x94+floor(-73*128/256)). After 256 steps, color=4B0082 exactly, fading=0, 10-cycle hold restarts.
- mode=0, step_dn at index 0 -> next cycle index=6, color=FA1010, wrap stays 0. step_up and step_dn together -> no change.
- mode=1, step_up at fade step 100 from 9400D3->4B0082 -> new src = colour at step 100, dst=0000FF, index=2, k restarts at 0. The fade ends exactly at 0000FF.
- enable=0 for 50 cycles mid-hold and mid-fade -> color, index and counters frozen; step_up pulses ignored. Resume continues from the same count.
- RST_N low for 1 cycle asynchronously mid-fade (not clock-aligned) -> color=9400D3, index=0, fading=0 immediately.
